// File: rtl/safecrack_key_arbiter_if.sv
// Digit handshake between the keypad front end and the safe FSM.
// master: drives digit_valid/digit, samples digit_ready; slave: the reverse.
interface safecrack_key_arbiter_if;
  logic       digit_valid;
  logic [1:0] digit;
  logic       digit_ready;

  modport master (
    output digit_valid,
    output digit,
    input  digit_ready
  );

  modport slave (
    input  digit_valid,
    input  digit,
    output digit_ready
  );
endinterface

// File: rtl/safecrack_key_arbiter.sv
// Keypad front end: sync + debounce four active-low keys, queue presses,
// round-robin grant onto the digit valid/ready link, flush on inhibit.
// Ports: clk, rst (sync, active high), keys_n, inhibit, clr_ovf,
//        dig (master: digit_valid/digit out, digit_ready in),
//        keys_stable, pending, overflow.
module safecrack_key_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_KEYS        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_n,
  input  logic                inhibit,
  input  logic                clr_ovf,
  safecrack_key_arbiter_if.master dig,
  output logic [NUM_KEYS-1:0] keys_stable,
  output logic [NUM_KEYS-1:0] pending,
  output logic                overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] pe, gnt;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic                valid_q, valid_d;
  logic [1:0]          digit_q, digit_d;
  logic [1:0]          rr_q, rr_d;
  logic [1:0]          gidx, scan;
  logic                gany, load, drop;
  logic                ovf_q, ovf_d;

  // Debounce: a key level is accepted only after it has differed
  // from the stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    pe       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        pe[i]       = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Round-robin scan starting at rr_q over registered pending only.
  always_comb begin
    gany = 1'b0;
    gidx = rr_q;
    scan = rr_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      scan = rr_q + 2'(k);
      if (!gany && pend_q[scan]) begin
        gany = 1'b1;
        gidx = scan;
      end
    end
  end

  assign load = (~valid_q | dig.digit_ready) & ~inhibit;

  always_comb begin
    gnt = '0;
    if (load && gany) gnt[gidx] = 1'b1;
  end

  // A new press on a still-pending key that is not granted this edge is lost.
  assign drop   = ~inhibit & |(pe & pend_q & ~gnt);
  assign pend_d = inhibit ? '0 : ((pend_q & ~gnt) | pe);
  assign ovf_d  = drop | (ovf_q & ~clr_ovf);

  always_comb begin
    valid_d = valid_q;
    digit_d = digit_q;
    rr_d    = rr_q;
    if (inhibit) begin
      valid_d = 1'b0;
    end else if (load) begin
      if (gany) begin
        valid_d = 1'b1;
        digit_d = gidx;
        rr_d    = gidx + 2'd1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      valid_q  <= 1'b0;
      digit_q  <= 2'd0;
      rr_q     <= 2'd0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= ~keys_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      digit_q  <= digit_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dig.digit_valid = valid_q;
  assign dig.digit       = digit_q;
  assign keys_stable     = stable_q;
  assign pending         = pend_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_safecrack_key_arbiter.sv
// Directed bench for safecrack_key_arbiter with DEBOUNCE_CYCLES=4:
// cycle-exact vector table plus multi-cycle handshake scenarios.
module tb_safecrack_key_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys_n;
  logic       inhibit;
  logic       clr_ovf;
  logic [3:0] keys_stable;
  logic [3:0] pending;
  logic       overflow;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int got_d [$];
  int got_t [$];

  safecrack_key_arbiter_if dif ();

  safecrack_key_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .NUM_KEYS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keys_n(keys_n),
    .inhibit(inhibit),
    .clr_ovf(clr_ovf),
    .dig(dif),
    .keys_stable(keys_stable),
    .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Transfer log: every accepted digit and the cycle it was accepted.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && dif.digit_valid && dif.digit_ready) begin
      got_d.push_back(int'(dif.digit));
      got_t.push_back(cyc);
    end
  end

  typedef struct {
    logic [3:0] kn;
    logic       rdy;
    logic       v;
    logic [1:0] d;
    logic [3:0] st;
    logic [3:0] pd;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic [3:0] kn, input logic rdy,
                              input logic v, input logic [1:0] d,
                              input logic [3:0] st, input logic [3:0] pd);
    vec_t t;
    t.kn  = kn;
    t.rdy = rdy;
    t.v   = v;
    t.d   = d;
    t.st  = st;
    t.pd  = pd;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input int n);
    keys_n = ~m;
    repeat (n) step();
  endtask

  task automatic release_keys(input int n);
    keys_n = 4'hF;
    repeat (n) step();
  endtask

  initial begin
    rst             = 1'b1;
    keys_n          = 4'hF;
    inhibit         = 1'b0;
    clr_ovf         = 1'b0;
    dif.digit_ready = 1'b1;

    // single press of KEY1, then release
    for (int i = 0; i < 5; i++) add(4'b1101, 1, 0, 2'd0, 4'b0000, 4'b0000);
    add(4'b1101, 1, 0, 2'd0, 4'b0010, 4'b0010);
    add(4'b1101, 1, 1, 2'd1, 4'b0010, 4'b0000);
    add(4'b1101, 1, 0, 2'd1, 4'b0010, 4'b0000);
    for (int i = 0; i < 5; i++) add(4'b1111, 1, 0, 2'd1, 4'b0010, 4'b0000);
    add(4'b1111, 1, 0, 2'd1, 4'b0000, 4'b0000);
    add(4'b1111, 1, 0, 2'd1, 4'b0000, 4'b0000);
    // 3-cycle bounce on KEY0 is rejected
    for (int i = 0; i < 3; i++) add(4'b1110, 1, 0, 2'd1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) add(4'b1111, 1, 0, 2'd1, 4'b0000, 4'b0000);
    // real KEY0 press
    for (int i = 0; i < 5; i++) add(4'b1110, 1, 0, 2'd1, 4'b0000, 4'b0000);
    add(4'b1110, 1, 0, 2'd1, 4'b0001, 4'b0001);
    add(4'b1110, 1, 1, 2'd0, 4'b0001, 4'b0000);
    add(4'b1110, 1, 0, 2'd0, 4'b0001, 4'b0000);
    for (int i = 0; i < 5; i++) add(4'b1111, 1, 0, 2'd0, 4'b0001, 4'b0000);
    add(4'b1111, 1, 0, 2'd0, 4'b0000, 4'b0000);

    repeat (2) step();
    chk("rst valid", int'(dif.digit_valid), 0);
    chk("rst digit", int'(dif.digit), 0);
    chk("rst stable", int'(keys_stable), 0);
    chk("rst pending", int'(pending), 0);
    chk("rst overflow", int'(overflow), 0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      keys_n          = tbl[i].kn;
      dif.digit_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d valid", i), int'(dif.digit_valid), int'(tbl[i].v));
      chk($sformatf("vec%0d digit", i), int'(dif.digit), int'(tbl[i].d));
      chk($sformatf("vec%0d stable", i), int'(keys_stable), int'(tbl[i].st));
      chk($sformatf("vec%0d pending", i), int'(pending), int'(tbl[i].pd));
      chk($sformatf("vec%0d ovf", i), int'(overflow), 0);
    end

    // backpressure and overflow on KEY2
    dif.digit_ready = 1'b0;
    press(4'b0100, 8);
    release_keys(8);
    chk("bp valid", int'(dif.digit_valid), 1);
    chk("bp digit", int'(dif.digit), 2);
    chk("bp pending0", int'(pending), 0);
    press(4'b0100, 8);
    release_keys(8);
    chk("bp pending1", int'(pending), 4'b0100);
    chk("bp ovf0", int'(overflow), 0);
    press(4'b0100, 8);
    release_keys(8);
    chk("bp pending2", int'(pending), 4'b0100);
    chk("bp ovf1", int'(overflow), 1);
    chk("bp hold digit", int'(dif.digit), 2);
    got_d.delete();
    got_t.delete();
    dif.digit_ready = 1'b1;
    repeat (3) step();
    chk("bp xfers", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("bp xfer0", got_d[0], 2);
      chk("bp xfer1", got_d[1], 2);
    end
    chk("bp drained valid", int'(dif.digit_valid), 0);
    chk("bp drained pend", int'(pending), 0);
    chk("bp ovf sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("bp ovf clr", int'(overflow), 0);

    // round robin from rr_ptr=3: keys 1 and 3 together
    got_d.delete();
    got_t.delete();
    press(4'b1010, 8);
    release_keys(8);
    chk("rr1 xfers", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("rr1 first", got_d[0], 3);
      chk("rr1 second", got_d[1], 1);
      chk("rr1 b2b", got_t[1] - got_t[0], 1);
    end
    // rr_ptr now 2: keys 1 and 2 together -> 2 first
    got_d.delete();
    got_t.delete();
    press(4'b0110, 8);
    release_keys(8);
    chk("rr2 xfers", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("rr2 first", got_d[0], 2);
      chk("rr2 second", got_d[1], 1);
    end

    // inhibit flush
    dif.digit_ready = 1'b0;
    press(4'b0010, 8);
    release_keys(8);
    press(4'b0101, 8);
    release_keys(8);
    chk("inh pre valid", int'(dif.digit_valid), 1);
    chk("inh pre pend", int'(pending), 4'b0101);
    inhibit = 1'b1;
    step();
    inhibit = 1'b0;
    chk("inh valid", int'(dif.digit_valid), 0);
    chk("inh pend", int'(pending), 0);
    dif.digit_ready = 1'b1;
    got_d.delete();
    got_t.delete();
    inhibit = 1'b1;
    press(4'b1000, 8);
    inhibit = 1'b0;
    press(4'b1000, 4);
    chk("inh held stable", int'(keys_stable), 4'b1000);
    release_keys(8);
    chk("inh no xfer", got_d.size(), 0);
    chk("inh no pend", int'(pending), 0);
    chk("inh no ovf", int'(overflow), 0);

    // reset mid-transfer with keys 0 and 3 held through it
    dif.digit_ready = 1'b0;
    press(4'b0010, 8);
    release_keys(8);
    press(4'b1001, 8);
    chk("mr pre valid", int'(dif.digit_valid), 1);
    chk("mr pre pend", int'(pending), 4'b1001);
    rst = 1'b1;
    step();
    chk("mr valid", int'(dif.digit_valid), 0);
    chk("mr digit", int'(dif.digit), 0);
    chk("mr stable", int'(keys_stable), 0);
    chk("mr pend", int'(pending), 0);
    chk("mr ovf", int'(overflow), 0);
    rst = 1'b0;
    dif.digit_ready = 1'b1;
    got_d.delete();
    got_t.delete();
    press(4'b1001, 12);
    release_keys(8);
    chk("mr xfers", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("mr first", got_d[0], 0);
      chk("mr second", got_d[1], 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
